// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer turning bit-reversed FFT frames into natural order.
// Optional FFT_REORDER_SCALE_EN: outputs are arithmetically shifted right by LOG2N (1/N scaling).
module fft_bitrev_reorder #(
  parameter int N     = 32,
  parameter int LOG2N = 5,
  parameter int DW    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DW-1:0]    in_r_i,
  input  logic [DW-1:0]    in_i_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DW-1:0]    out_r_o,
  output logic [DW-1:0]    out_i_o,
  output logic [LOG2N-1:0] out_idx_o,
  output logic             out_last_o,
  output logic             frame_err_o
);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic [2*DW-1:0]    mem_q [2*N];
  logic [1:0]         full_q, full_d;
  logic               wbank_q, wbank_d, rbank_q, rbank_d;
  logic [LOG2N-1:0]   wcnt_q, wcnt_d, rcnt_q, rcnt_d, out_idx_q, out_idx_d;
  logic               out_valid_q, out_valid_d, out_last_q, out_last_d, frame_err_q, frame_err_d;
  logic [DW-1:0]      out_r_q, out_r_d, out_i_q, out_i_d;
  logic               wr, ld, wlast, rlast;
  logic [2*DW-1:0]    rd;
  logic signed [DW-1:0] rd_r, rd_i;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int k = 0; k < LOG2N; k++) r[k] = a[LOG2N-1-k];
    return r;
  endfunction

  assign in_ready_o = !full_q[wbank_q];
  assign wr    = in_valid_i && in_ready_o;
  assign wlast = wcnt_q == LAST;
  assign ld    = full_q[rbank_q] && (!out_valid_q || out_ready_i);
  assign rlast = rcnt_q == LAST;
  assign rd    = mem_q[{rbank_q, rcnt_q}];

`ifdef FFT_REORDER_SCALE_EN
  assign rd_r = $signed(rd[2*DW-1:DW]) >>> LOG2N;
  assign rd_i = $signed(rd[DW-1:0]) >>> LOG2N;
`else
  assign rd_r = rd[2*DW-1:DW];
  assign rd_i = rd[DW-1:0];
`endif

  always_comb begin
    full_d = full_q;
    if (wr && wlast) full_d[wbank_q] = 1'b1;
    if (ld && rlast) full_d[rbank_q] = 1'b0;
    wcnt_d      = wr ? (wlast ? '0 : wcnt_q + 1'b1) : wcnt_q;
    wbank_d     = wbank_q ^ (wr && wlast);
    rcnt_d      = ld ? (rlast ? '0 : rcnt_q + 1'b1) : rcnt_q;
    rbank_d     = rbank_q ^ (ld && rlast);
    out_valid_d = ld || (out_valid_q && !out_ready_i);
    out_r_d     = ld ? rd_r : out_r_q;
    out_i_d     = ld ? rd_i : out_i_q;
    out_idx_d   = ld ? rcnt_q : out_idx_q;
    out_last_d  = ld ? rlast : out_last_q;
    frame_err_d = frame_err_q || (wr && (in_last_i != wlast));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q      <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Sample storage needs no reset; the full flags decide what is valid.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr) mem_q[{wbank_q, bitrev(wcnt_q)}] <= {in_r_i, in_i_i};
  end

  assign out_valid_o = out_valid_q;
  assign out_r_o     = out_r_q;
  assign out_i_o     = out_i_q;
  assign out_idx_o   = out_idx_q;
  assign out_last_o  = out_last_q;
  assign frame_err_o = frame_err_q;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: directed checks of ordering, latency, backpressure, framing and reset.
module tb_fft_bitrev_reorder;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic in_ready, out_valid, out_last, frame_err;
  logic [31:0] in_r = 0, in_i = 0, out_r, out_i;
  logic [4:0] out_idx;
  int total = 0, bad = 0, wk = 0, wf = 0, oidx = 0, lastpos = 31;
  int exp_q[$];
  bit special = 0;

  always #5 clk = ~clk;

  fft_bitrev_reorder dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_r_i(in_r), .in_i_i(in_i), .in_last_i(in_last), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_r_o(out_r), .out_i_o(out_i), .out_idx_o(out_idx),
    .out_last_o(out_last), .frame_err_o(frame_err)
  );

  function automatic int br5(int k);
    int r = 0;
    for (int b = 0; b < 5; b++) if (((k >> b) & 1) != 0) r |= 1 << (4 - b);
    return r;
  endfunction

  function automatic int val(int base, int n);
    if (base < 0) return n == 3 ? -64 : n == 4 ? 31 : n == 5 ? -1 : n;
    return base + n;
  endfunction

  function automatic logic [31:0] sc(int v);
`ifdef FFT_REORDER_SCALE_EN
    return 32'(v >>> 5);
`else
    return 32'(v);
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(bit v, bit r);
    int base, n;
    bit acc, cons;
    base = special ? -1 : wf * 32;
    n = br5(wk);
    in_valid = v;
    out_ready = r;
    in_r = 32'(val(base, n));
    in_i = 32'(-val(base, n));
    in_last = (wk == lastpos);
    if (out_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
      else begin
        chk("idx", 32'(out_idx), 32'(oidx));
        chk("re", out_r, sc(val(exp_q[0], oidx)));
        chk("im", out_i, sc(-val(exp_q[0], oidx)));
        chk("last", 32'(out_last), 32'(oidx == 31));
      end
    end
    acc = v && in_ready;
    cons = out_valid && r;
    @(negedge clk);
    if (cons) begin
      if (oidx == 31) begin
        oidx = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else oidx++;
    end
    if (acc) begin
      if (wk == 31) begin
        exp_q.push_back(base);
        wk = 0;
        wf++;
      end else wk++;
    end
  endtask

  task automatic drain();
    in_valid = 0;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) step(0, 1);
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int gaps, bubbles, abase;
    bit seen;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_re", out_r, 32'd0);
    chk("rst_im", out_i, 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1;
    @(negedge clk);
    // single frame: latency and natural ordering
    for (int s = 0; s < 32; s++) step(1, 1);
    chk("lat_t", 32'(out_valid), 32'd0);
    step(0, 1);
    chk("lat_t1_valid", 32'(out_valid), 32'd1);
    chk("lat_t1_idx", 32'(out_idx), 32'd0);
    drain();
    chk("err_clean", 32'(frame_err), 32'd0);
    // four back-to-back frames at full rate
    gaps = 0; bubbles = 0; seen = 0;
    for (int c = 0; c < 300 && (c < 128 || exp_q.size() > 0); c++) begin
      if (c < 128 && !in_ready) gaps++;
      if (out_valid) seen = 1;
      else if (seen && exp_q.size() > 0) bubbles++;
      step(c < 128, 1);
    end
    chk("stream_gaps", 32'(gaps), 32'd0);
    chk("stream_bubbles", 32'(bubbles), 32'd0);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    // backpressure: both banks fill, output held
    abase = wf * 32;
    gaps = 0;
    for (int c = 0; c < 64; c++) begin
      if (!in_ready) gaps++;
      step(1, 0);
    end
    chk("bp_gaps", 32'(gaps), 32'd0);
    chk("bp_full", 32'(in_ready), 32'd0);
    repeat (3) step(1, 0);
    chk("bp_block", 32'(in_ready), 32'd0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_idx", 32'(out_idx), 32'd0);
    in_valid = 0;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      if (out_valid && exp_q[0] == abase) chk("bp_ready", 32'(in_ready), 32'(out_idx == 31));
      step(0, 1);
    end
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_ready_end", 32'(in_ready), 32'd1);
    // misplaced in_last: sticky error, count still authoritative
    lastpos = 10;
    for (int s = 0; s < 32; s++) step(1, 1);
    lastpos = 31;
    chk("err_set", 32'(frame_err), 32'd1);
    drain();
    for (int s = 0; s < 32; s++) step(1, 1);
    drain();
    chk("err_sticky", 32'(frame_err), 32'd1);
    // reset mid-frame and mid-drain
    for (int s = 0; s < 49; s++) step(1, 1);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    in_valid = 0;
    rst_n = 0;
    @(negedge clk);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_re", out_r, 32'd0);
    chk("mrst_im", out_i, 32'd0);
    chk("mrst_idx", 32'(out_idx), 32'd0);
    chk("mrst_last", 32'(out_last), 32'd0);
    chk("mrst_err", 32'(frame_err), 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    wk = 0;
    oidx = 0;
    rst_n = 1;
    @(negedge clk);
    for (int s = 0; s < 32; s++) step(1, 1);
    drain();
    chk("post_rst_err", 32'(frame_err), 32'd0);
    // signed values through the (optionally scaling) output path
    special = 1;
    for (int s = 0; s < 32; s++) step(1, 1);
    special = 0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
